// File: rtl/apb4_reg_slave_if.sv
// APB4 bus bundle between a requester and the register-bank slave.
// The master drives address, control and write data; the slave answers.
interface apb4_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb4_reg_slave.sv
// APB4 register-bank slave: byte-strobed RW words, hardware-fed RO words,
// fixed wait states, PSLVERR on bad accesses and a protocol-violation monitor.
module apb4_reg_slave #(
    parameter int                   ADDR_WIDTH  = 32,
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   NUM_REGS    = 8,
    parameter int                   WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
    input  logic                           pclk,
    input  logic                           preset,
    apb4_reg_slave_if.slave                bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic                           proto_clr,
    output logic                           proto_err,
    output logic [7:0]                     proto_cnt
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [ADDR_WIDTH-1:0] word;
    logic [IW-1:0]         idx;
    logic                  in_range;
    logic                  misaligned;
    logic                  ro_hit;
    logic                  bad;
    logic                  setup;
    logic                  access;
    logic                  last;
    logic                  commit;
    logic                  viol;
    logic [DATA_WIDTH-1:0] rd_word;

    // Address decode; out-of-range indices are folded to 0 and flagged bad.
    always_comb begin
        word       = bus.paddr >> LSB;
        in_range   = word < ADDR_WIDTH'(NUM_REGS);
        idx        = in_range ? word[IW-1:0] : '0;
        misaligned = (bus.paddr & OFS_MASK) != '0;
        ro_hit     = in_range & RO_MASK[idx];
        bad        = misaligned | !in_range | (bus.pwrite & ro_hit);
        setup      = bus.psel & !bus.penable;
        access     = bus.psel & bus.penable;
        last       = cnt == 4'(WAIT_STATES);
        rd_word    = ro_hit ? ro_in[32'(idx) * DATA_WIDTH +: DATA_WIDTH]
                            : regs[idx];
    end

    // Bus response, commit strobe and violation detect, silenced in reset.
    always_comb begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
        commit      = 1'b0;
        viol        = 1'b0;
        if (!preset) begin
            if (state == IDLE) begin
                viol        = access;
                bus.pready  = access;
                bus.pslverr = access;
            end else begin
                viol = !access;
                if (access && last) begin
                    bus.pready  = 1'b1;
                    bus.pslverr = bad;
                    commit      = bus.pwrite & !bad;
                    if (!bus.pwrite && !bad) begin
                        bus.prdata = rd_word;
                    end
                end
            end
        end
    end

    // Transfer FSM with wait-state counter.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (setup) begin
                        state <= ACCESS;
                        cnt   <= '0;
                    end
                end
                ACCESS: begin
                    if (access) begin
                        if (last) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else if (setup) begin
                        cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Register storage with byte-lane writes and a one-cycle commit pulse.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                wr_pulse[idx] <= 1'b1;
                for (int b = 0; b < NB; b++) begin
                    if (bus.pstrb[b]) begin
                        regs[idx][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Sticky violation flag and saturating count; a coincident clear
    // still records the new violation.
    always_ff @(posedge pclk) begin
        if (preset) begin
            proto_err <= 1'b0;
            proto_cnt <= '0;
        end else if (proto_clr) begin
            proto_err <= viol;
            proto_cnt <= viol ? 8'd1 : 8'd0;
        end else if (viol) begin
            proto_err <= 1'b1;
            if (proto_cnt != 8'hFF) begin
                proto_cnt <= proto_cnt + 8'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end
endmodule

// File: tb/tb_apb4_reg_slave.sv
// Directed bench for apb4_reg_slave: a zero-wait and a three-wait instance,
// both with register 3 read-only.
module tb_apb4_reg_slave;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        dsel;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic        clr;

    logic [NR*DW-1:0] q0, q3, ro0, ro3;
    logic [NR-1:0]    wp0, wp3;
    logic             perr0, perr3;
    logic [7:0]       pcnt0, pcnt3;

    apb4_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    apb4_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    assign bus0.paddr   = paddr;
    assign bus0.pwdata  = pwdata;
    assign bus0.pstrb   = pstrb;
    assign bus0.pwrite  = pwrite;
    assign bus0.psel    = psel & !dsel;
    assign bus0.penable = penable & !dsel;
    assign bus3.paddr   = paddr;
    assign bus3.pwdata  = pwdata;
    assign bus3.pstrb   = pstrb;
    assign bus3.pwrite  = pwrite;
    assign bus3.psel    = psel & dsel;
    assign bus3.penable = penable & dsel;

    wire        pready  = dsel ? bus3.pready : bus0.pready;
    wire        pslverr = dsel ? bus3.pslverr : bus0.pslverr;
    wire [31:0] prdata  = dsel ? bus3.prdata : bus0.prdata;
    wire [7:0]  wpulse  = dsel ? wp3 : wp0;
    wire        perr    = dsel ? perr3 : perr0;
    wire [7:0]  pcnt    = dsel ? pcnt3 : pcnt0;

    apb4_reg_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
        .WAIT_STATES(0), .RO_MASK(8'h08)
    ) u0 (
        .pclk(clk), .preset(rst), .bus(bus0.slave),
        .reg_q(q0), .ro_in(ro0), .wr_pulse(wp0),
        .proto_clr(clr), .proto_err(perr0), .proto_cnt(pcnt0)
    );

    apb4_reg_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
        .WAIT_STATES(3), .RO_MASK(8'h08)
    ) u3 (
        .pclk(clk), .preset(rst), .bus(bus3.slave),
        .reg_q(q3), .ro_in(ro3), .wr_pulse(wp3),
        .proto_clr(clr), .proto_err(perr3), .proto_cnt(pcnt3)
    );

    typedef struct {
        logic        d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        err;
        logic [31:0] rd;
        int          qi;
        logic [31:0] q;
        logic [7:0]  pulse;
    } vec_t;

    vec_t tv[18];
    int   n_app = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_app++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] qslice(input logic d, input int i);
        return d ? q3[i*32 +: 32] : q0[i*32 +: 32];
    endfunction

    task automatic wait_ready(output int w, output logic err,
                              output logic [31:0] rd);
        logic seen;
        seen = 1'b0;
        w    = 0;
        err  = 1'b0;
        rd   = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pready) begin
                seen = 1'b1;
                err  = pslverr;
                rd   = prdata;
            end else begin
                w++;
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            chk("pready_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic xfer(input logic d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        output int w, output logic err,
                        output logic [31:0] rd);
        @(posedge clk);
        #1;
        dsel    = d;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = s;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        wait_ready(w, err, rd);
    endtask

    int          w;
    logic        err;
    logic [31:0] rd;

    initial begin
        tv[0]  = '{1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 1, 32'hDEADBEEF, 8'h02};
        tv[1]  = '{1'b0, 1'b0, 32'h04, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 8'h00};
        tv[2]  = '{1'b0, 1'b1, 32'h08, 32'h11223344, 4'hF, 0, 1'b0, 32'h0, 2, 32'h11223344, 8'h04};
        tv[3]  = '{1'b0, 1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 0, 1'b0, 32'h0, 2, 32'h11BB33DD, 8'h04};
        tv[4]  = '{1'b0, 1'b0, 32'h08, 32'h0, 4'h0, 0, 1'b0, 32'h11BB33DD, 2, 32'h11BB33DD, 8'h00};
        tv[5]  = '{1'b0, 1'b0, 32'h02, 32'h0, 4'h0, 0, 1'b1, 32'h0, 0, 32'h0, 8'h00};
        tv[6]  = '{1'b0, 1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, 0, 1'b1, 32'h0, 0, 32'h0, 8'h00};
        tv[7]  = '{1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1, 32'h0, 0, 32'h0, 8'h00};
        tv[8]  = '{1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 1'b1, 32'h0, 0, 32'h0, 8'h00};
        tv[9]  = '{1'b0, 1'b1, 32'h0C, 32'h12345678, 4'hF, 0, 1'b1, 32'h0, 3, 32'h0, 8'h00};
        tv[10] = '{1'b0, 1'b0, 32'h0C, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE0001, 3, 32'h0, 8'h00};
        tv[11] = '{1'b0, 1'b1, 32'h1C, 32'hFFFFFFFF, 4'h0, 0, 1'b0, 32'h0, 7, 32'h0, 8'h80};
        tv[12] = '{1'b0, 1'b0, 32'h1C, 32'h0, 4'h0, 0, 1'b0, 32'h0, 7, 32'h0, 8'h00};
        tv[13] = '{1'b1, 1'b0, 32'h00, 32'h0, 4'h0, 3, 1'b0, 32'h0, 0, 32'h0, 8'h00};
        tv[14] = '{1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 3, 1'b0, 32'h0, 4, 32'hA5A5A5A5, 8'h10};
        tv[15] = '{1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 3, 1'b0, 32'hA5A5A5A5, 4, 32'hA5A5A5A5, 8'h00};
        tv[16] = '{1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 3, 1'b0, 32'h0BADF00D, 3, 32'h0, 8'h00};
        tv[17] = '{1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 3, 1'b1, 32'h0, 0, 32'h0, 8'h00};

        for (int i = 0; i < NR; i++) begin
            ro0[i*32 +: 32] = 32'h5A5A0000 + i;
            ro3[i*32 +: 32] = 32'h6B6B0000 + i;
        end
        ro0[3*32 +: 32] = 32'hCAFE0001;
        ro3[3*32 +: 32] = 32'h0BADF00D;

        rst = 1'b1; dsel = 1'b0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_reg_q", q0[31:0] | q0[63:32] | q0[255:224], 32'h0);
        chk("rst_wr_pulse", {24'h0, wp0}, 32'h0);
        chk("rst_proto", {23'h0, perr0, pcnt0}, 32'h0);
        chk("rst_pready", {31'h0, bus0.pready}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            xfer(tv[i].d, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].strb,
                 w, err, rd);
            chk($sformatf("v%0d_waits", i), 32'(w), 32'(tv[i].waits));
            chk($sformatf("v%0d_pslverr", i), {31'h0, err}, {31'h0, tv[i].err});
            chk($sformatf("v%0d_prdata", i), rd, tv[i].rd);
            chk($sformatf("v%0d_reg_q", i), qslice(tv[i].d, tv[i].qi), tv[i].q);
            chk($sformatf("v%0d_wr_pulse", i), {24'h0, wpulse}, {24'h0, tv[i].pulse});
        end

        // wr_pulse lasts exactly one cycle
        xfer(1'b0, 1'b1, 32'h14, 32'h00C0FFEE, 4'hF, w, err, rd);
        chk("pulse_on", {24'h0, wpulse}, 32'h20);
        @(posedge clk);
        #1;
        chk("pulse_off", {24'h0, wpulse}, 32'h0);
        chk("pulse_reg", qslice(1'b0, 5), 32'h00C0FFEE);

        // penable without setup
        @(posedge clk);
        #1;
        dsel = 1'b1; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hFFFFFFFF;
        pstrb = 4'hF; psel = 1'b1; penable = 1'b1;
        @(negedge clk);
        chk("noset_pready", {31'h0, pready}, 32'h1);
        chk("noset_pslverr", {31'h0, pslverr}, 32'h1);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        chk("noset_proto", {23'h0, perr, pcnt}, {23'h0, 1'b1, 8'd1});
        chk("noset_reg", qslice(1'b1, 5), 32'h0);

        // psel dropped during the wait
        @(posedge clk);
        #1;
        psel = 1'b1;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(negedge clk);
        chk("drop_pready", {31'h0, pready}, 32'h0);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_cnt", {24'h0, pcnt}, 32'd2);
        chk("drop_reg", qslice(1'b1, 5), 32'h0);
        chk("drop_pulse", {24'h0, wpulse}, 32'h0);

        // penable dropped with psel held restarts the wait
        pwrite = 1'b0; paddr = 32'h10; psel = 1'b1;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        penable = 1'b0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        chk("restart_cnt", {24'h0, pcnt}, 32'd3);
        wait_ready(w, err, rd);
        chk("restart_waits", 32'(w), 32'd3);
        chk("restart_prdata", rd, 32'hA5A5A5A5);

        // saturation
        @(posedge clk);
        #1;
        psel = 1'b1; penable = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        chk("sat_proto", {23'h0, perr, pcnt}, {23'h0, 1'b1, 8'd255});

        // clear, then clear coinciding with a violation
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_proto", {23'h0, perr, pcnt}, 32'h0);
        clr = 1'b1; psel = 1'b1; penable = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; psel = 1'b0; penable = 1'b0;
        chk("clr_viol_proto", {23'h0, perr, pcnt}, {23'h0, 1'b1, 8'd1});

        // reset in the middle of a waited write
        pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h12345678; pstrb = 4'hF;
        psel = 1'b1;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("mid_rst_pready", {31'h0, pready}, 32'h0);
        chk("mid_rst_reg", qslice(1'b1, 6), 32'h0);
        chk("mid_rst_pulse", {24'h0, wpulse}, 32'h0);
        chk("mid_rst_proto", {23'h0, perr, pcnt}, 32'h0);
        xfer(1'b1, 1'b1, 32'h18, 32'h12345678, 4'hF, w, err, rd);
        chk("post_rst_waits", 32'(w), 32'd3);
        chk("post_rst_pslverr", {31'h0, err}, 32'h0);
        chk("post_rst_reg", qslice(1'b1, 6), 32'h12345678);
        chk("post_rst_pulse", {24'h0, wpulse}, 32'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_bad);
        $finish;
    end
endmodule
